// File: rtl/serial_fifo_interface.sv
// UART transceiver with a TX FIFO feeding the serialiser and an RX FIFO
// (first-word-fall-through) fed by the deserialiser, plus sticky error flags.
module serial_fifo_interface #(
  parameter int unsigned WTIME     = 16'h02c1,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_txd_in,
  output logic                   uart_rxd_out,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   err_overrun,
  output logic                   err_frame,
  output logic                   err_parity,
  input  logic                   err_clear
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(WTIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(WTIME / 2 - 1);
  localparam logic [2:0]  DBIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [7:0]  DMASK     = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic        PAR_EN    = (PARITY != 0);
  localparam logic        PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  function automatic logic parity_bit(input logic [7:0] d);
    return (^(d & DMASK)) ^ PAR_ODD;
  endfunction

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_load;
  logic [7:0]    tx_head;

  assign i_ready  = (tx_cnt_q != FULL);
  assign tx_push  = i_valid & i_ready;
  assign tx_head  = tx_mem[tx_rd_q];
  assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_load);
  assign tx_count = tx_cnt_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_load) tx_rd_q <= tx_rd_q + AW'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // TX serialiser
  state_t      tx_st_q;
  logic [15:0] tx_tmr_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_sh_q;
  logic        tx_par_q;
  logic        txd_q;
  logic        tx_bit_end;
  logic        tx_line;

  assign tx_bit_end   = (tx_tmr_q == BIT_LAST);
  // A frame is fetched from idle, or straight out of a finished stop bit.
  assign tx_load      = (tx_cnt_q != '0) &&
                        ((tx_st_q == ST_IDLE) || ((tx_st_q == ST_STOP) && tx_bit_end));
  assign uart_rxd_out = txd_q;

  always_comb begin
    tx_line = 1'b1;
    case (tx_st_q)
      ST_START: tx_line = 1'b0;
      ST_DATA:  tx_line = tx_sh_q[0];
      ST_PAR:   tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= ST_IDLE;
      tx_tmr_q <= '0;
      tx_idx_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      txd_q <= tx_line;
      if (tx_load) begin
        tx_st_q  <= ST_START;
        tx_tmr_q <= '0;
        tx_sh_q  <= tx_head & DMASK;
        tx_par_q <= parity_bit(tx_head);
      end else begin
        case (tx_st_q)
          ST_IDLE: tx_tmr_q <= '0;
          ST_START: begin
            if (tx_bit_end) begin
              tx_st_q  <= ST_DATA;
              tx_tmr_q <= '0;
              tx_idx_q <= '0;
            end else begin
              tx_tmr_q <= tx_tmr_q + 16'd1;
            end
          end
          ST_DATA: begin
            if (tx_bit_end) begin
              tx_tmr_q <= '0;
              tx_sh_q  <= tx_sh_q >> 1;
              if (tx_idx_q == DBIT_LAST) tx_st_q <= PAR_EN ? ST_PAR : ST_STOP;
              else                       tx_idx_q <= tx_idx_q + 3'd1;
            end else begin
              tx_tmr_q <= tx_tmr_q + 16'd1;
            end
          end
          ST_PAR: begin
            if (tx_bit_end) begin
              tx_st_q  <= ST_STOP;
              tx_tmr_q <= '0;
            end else begin
              tx_tmr_q <= tx_tmr_q + 16'd1;
            end
          end
          ST_STOP: begin
            if (tx_bit_end) begin
              tx_st_q  <= ST_IDLE;
              tx_tmr_q <= '0;
            end else begin
              tx_tmr_q <= tx_tmr_q + 16'd1;
            end
          end
          default: tx_st_q <= ST_IDLE;
        endcase
      end
    end
  end

  // RX line synchroniser and edge detect
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_txd_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // RX deserialiser
  state_t      rx_st_q;
  logic [15:0] rx_tmr_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_sh_q;
  logic        rx_pbad_q;
  logic        rx_done_q;
  logic        fe_set_q, pe_set_q;
  logic        rx_bit_end;

  assign rx_bit_end = (rx_tmr_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= ST_IDLE;
      rx_tmr_q  <= '0;
      rx_idx_q  <= '0;
      rx_pbad_q <= 1'b0;
      rx_done_q <= 1'b0;
      fe_set_q  <= 1'b0;
      pe_set_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      fe_set_q  <= 1'b0;
      pe_set_q  <= 1'b0;
      case (rx_st_q)
        ST_IDLE: begin
          rx_tmr_q <= '0;
          if (rx_fall) begin
            rx_st_q   <= ST_START;
            rx_pbad_q <= 1'b0;
          end
        end
        ST_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (rx_tmr_q == HALF_LAST) begin
            rx_tmr_q <= '0;
            if (rx_s2_q) begin
              rx_st_q <= ST_IDLE;
            end else begin
              rx_st_q  <= ST_DATA;
              rx_idx_q <= '0;
              rx_sh_q  <= '0;
            end
          end else begin
            rx_tmr_q <= rx_tmr_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_bit_end) begin
            rx_tmr_q          <= '0;
            rx_sh_q[rx_idx_q] <= rx_s2_q;
            if (rx_idx_q == DBIT_LAST) rx_st_q <= PAR_EN ? ST_PAR : ST_STOP;
            else                       rx_idx_q <= rx_idx_q + 3'd1;
          end else begin
            rx_tmr_q <= rx_tmr_q + 16'd1;
          end
        end
        ST_PAR: begin
          if (rx_bit_end) begin
            rx_tmr_q  <= '0;
            rx_pbad_q <= (rx_s2_q != parity_bit(rx_sh_q));
            rx_st_q   <= ST_STOP;
          end else begin
            rx_tmr_q <= rx_tmr_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_bit_end) begin
            rx_tmr_q  <= '0;
            rx_st_q   <= ST_IDLE;
            rx_done_q <= rx_s2_q & ~rx_pbad_q;
            fe_set_q  <= ~rx_s2_q;
            pe_set_q  <= rx_pbad_q;
          end else begin
            rx_tmr_q <= rx_tmr_q + 16'd1;
          end
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_full, rx_wr, rx_pop, ovr_set;

  assign rx_full  = (rx_cnt_q == FULL);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign rx_wr    = rx_done_q & ~rx_full;
  assign ovr_set  = rx_done_q & rx_full;
  assign o_valid  = (rx_cnt_q != '0);
  assign rx_pop   = o_valid & o_ready;
  assign o_data   = o_valid ? rx_mem[rx_rd_q] : 8'h00;
  assign rx_cnt_d = rx_cnt_q + CW'(rx_wr) - CW'(rx_pop);
  assign rx_count = rx_cnt_q;

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_q] <= rx_sh_q & DMASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_wr)  rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Sticky error flags; a set event outranks a clear in the same cycle.
  logic err_ovr_q, err_fe_q, err_pe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovr_q <= 1'b0;
      err_fe_q  <= 1'b0;
      err_pe_q  <= 1'b0;
    end else begin
      err_ovr_q <= ovr_set  | (err_ovr_q & ~err_clear);
      err_fe_q  <= fe_set_q | (err_fe_q & ~err_clear);
      err_pe_q  <= pe_set_q | (err_pe_q & ~err_clear);
    end
  end

  assign err_overrun = err_ovr_q;
  assign err_frame   = err_fe_q;
  assign err_parity  = err_pe_q;

endmodule

// File: doc/serial_fifo_interface.md
SERIAL_FIFO_INTERFACE -- requirements
Module: serial_fifo_interface

Interface
REQ-001 SHALL have parameter WTIME, default 16'h02c1: clocks per UART bit period (>=4).
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter DEPTH, default 16: entries per FIFO (power of two, >=2).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- uart_txd_in  in  1  serial receive line, asynchronous
- uart_rxd_out  out  1  serial transmit line
- i_data  in  8  TX byte
- i_valid  in  1  TX byte valid
- i_ready  out  1  TX FIFO accepts
- o_data  out  8  RX byte, zero-extended above DATA_BITS
- o_valid  out  1  RX byte available
- o_ready  in  1  consumer accepts
- tx_count  out  $clog2(DEPTH)+1  TX FIFO occupancy
- rx_count  out  $clog2(DEPTH)+1  RX FIFO occupancy
- err_overrun  out  1  sticky, RX byte dropped on full FIFO
- err_frame  out  1  sticky, stop bit sampled low
- err_parity  out  1  sticky, parity mismatch
- err_clear  in  1  clears all sticky errors

Function
REQ-006 SHALL drive i_ready = (tx_count != DEPTH) and push i_data on i_valid & i_ready; it SHALL never push when full.
REQ-007 SHALL run the TX FSM through IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE, holding each bit for exactly WTIME cycles, sending LSB first, transmitting only i_data[DATA_BITS-1:0].
REQ-008 SHALL pop the TX FIFO on the IDLE->START transition; uart_rxd_out SHALL be registered and go low exactly 2 cycles after the accepting edge when TX is idle.
REQ-009 SHALL start the next frame on the cycle after the stop bit ends if the TX FIFO is non-empty, with no idle gap.
REQ-010 SHALL compute parity as the XOR of the data bits (even), inverted for odd.
REQ-011 SHALL synchronise uart_txd_in through 2 flops (reset value 1) before any use.
REQ-012 SHALL run the RX FSM through IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE; a synchronised falling edge in IDLE SHALL enter START.
REQ-013 SHALL resample in START at WTIME/2 (floor) cycles; if the line is high it SHALL return to IDLE with no error; otherwise it SHALL sample each later bit every WTIME cycles.
REQ-014 SHALL return RX to IDLE immediately after the stop-bit sample.
REQ-015 SHALL discard the byte and set err_frame on a low stop bit, or set err_parity on a parity mismatch; both flags may set on the same frame.
REQ-016 SHALL push a good byte into the RX FIFO one cycle after the stop sample; if rx_count == DEPTH at that cycle, SHALL drop it and set err_overrun, even when a pop occurs in the same cycle.
REQ-017 SHALL make the RX FIFO first-word-fall-through: o_valid = (rx_count != 0), o_data = head entry, pop on o_valid & o_ready.
REQ-018 SHALL let a simultaneous push and pop on a non-full FIFO leave its count unchanged and keep data in order; pointers SHALL wrap modulo DEPTH.
REQ-019 SHALL clear the sticky flags on err_clear; a flag set event in the same cycle SHALL win.

Reset
REQ-020 SHALL, on rst, empty both FIFOs, put both FSMs in IDLE, zero all counters and flags, and drive uart_rxd_out=1, i_ready=1, o_valid=0, o_data=0.
REQ-021 SHALL, on rst mid-frame, abort the frame, drive the line high the next cycle, and never push the partial RX byte.

Verification (WTIME=16, DEPTH=4, DATA_BITS=8 unless stated)
REQ-022 SHALL cover TX of 0xA5 with PARITY=0 -> uart_rxd_out = 0,1,0,1,0,0,1,0,1,1, each for 16 cycles, 160 cycles total, start bit 2 cycles after accept.
REQ-023 SHALL cover loopback (uart_rxd_out tied to uart_txd_in) with 0x00..0x05 offered back-to-back -> i_ready low while tx_count=4, all 6 bytes received in order, no errors.
REQ-024 SHALL cover PARITY=1 RX of 0x3C with parity bit 1 -> err_parity=1, o_valid stays 0; err_clear pulse -> err_parity=0.
REQ-025 SHALL cover an RX frame with stop bit 0 -> err_frame=1, rx_count unchanged.
REQ-026 SHALL cover o_ready=0 with 5 good RX frames 0x11..0x15 -> rx_count=4, err_overrun=1, o_data=0x11.
REQ-027 SHALL cover a 4-cycle low glitch on uart_txd_in -> no byte and no error; rst asserted mid-TX-frame -> uart_rxd_out=1 next cycle, tx_count=0.
